// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and fetch sequencer for the single-cycle datapath.
// Computes PC+4, the branch target and the jump target, selects the next PC and
// sequences BOOT -> FETCH -> EXEC with a request/ready handshake to instruction memory.
//
// Handshake: imem_req_o is high for every cycle spent in FETCH and means "fetch the
// word at pc_o". The transfer completes at the first rising edge where imem_req_o and
// imem_ready_i are both high; imem_ready_i is a don't-care in every other state.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             branch_i,
    input  logic             zero_i,
    input  logic [31:0]      br_offset_i,
    input  logic             jump_i,
    input  logic [25:0]      jump_addr_i,
    input  logic             imem_ready_i,
    output logic             imem_req_o,
    output logic             instr_valid_o,
    output logic [31:0]      pc_o,
    output logic [31:0]      pc_plus4_o,
    output logic [31:0]      br_target_o,
    output logic [CNT_W-1:0] redirect_cnt_o,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    // Reset PC with the low two bits cleared so pc_o stays word aligned
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_pc;
    logic [31:0]      w_pc_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [31:0]      w_pc_plus4;
    logic [31:0]      w_br_sum;
    logic [31:0]      w_br_target;
    logic [31:0]      w_jump_target;
    logic             w_br_taken;
    logic             w_redirect;

    // Target arithmetic, all modulo 2^32 with alignment bits forced to zero
    always_comb begin
        w_pc_plus4    = r_pc + 32'd4;
        w_br_sum      = w_pc_plus4 + br_offset_i;
        w_br_target   = {w_br_sum[31:2], 2'b00};
        w_jump_target = {w_pc_plus4[31:28], jump_addr_i, 2'b00};
        w_br_taken    = branch_i & zero_i;
        w_redirect    = jump_i | w_br_taken;
    end

    // Next-state, next-PC and redirect-counter decode
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ready_i) begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!stall_i) begin
                    w_state_nxt = ST_FETCH;
                    // Jump has priority over a taken branch
                    if (jump_i) begin
                        w_pc_nxt = w_jump_target;
                    end else if (w_br_taken) begin
                        w_pc_nxt = w_br_target;
                    end else begin
                        w_pc_nxt = w_pc_plus4;
                    end
                    // Counter saturates at all-ones instead of wrapping
                    if (w_redirect && !(&r_cnt)) begin
                        w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    // State, PC and counter registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_BOOT;
            r_pc    <= RESET_PC_ALIGNED;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Outputs decoded from the registered state
    always_comb begin
        imem_req_o     = (r_state == ST_FETCH);
        instr_valid_o  = (r_state == ST_EXEC);
        pc_o           = r_pc;
        pc_plus4_o     = w_pc_plus4;
        br_target_o    = w_br_target;
        redirect_cnt_o = r_cnt;
        state_o        = r_state;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and fetch-sequencing stage of the single-cycle datapath.
- Consumes the word-aligned branch offset produced by the shift-left-two stage.
- Computes PC+4, the branch target and the jump target, and selects the next PC.
- Sequences instruction fetch with a simple request/ready handshake to instruction memory and holds the PC under stall.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
CNT_W, 16, width of the saturating taken-redirect counter.

Ports:
clk_i  input  1  clock; all state updates on rising edge.
rst_i  input  1  synchronous, active-high reset.
stall_i  input  1  hold current instruction, no PC update.
branch_i  input  1  current instruction is a conditional branch.
zero_i  input  1  ALU zero flag; branch taken when branch_i & zero_i.
br_offset_i  input  32  sign-extended offset already shifted left by two.
jump_i  input  1  current instruction is a jump.
jump_addr_i  input  26  instruction jump field.
imem_ready_i  input  1  instruction memory has data for pc_o.
imem_req_o  output  1  fetch request for address pc_o.
instr_valid_o  output  1  instruction at pc_o is valid for decode/execute.
pc_o  output  32  current PC.
pc_plus4_o  output  32  pc_o + 4, combinational.
br_target_o  output  32  pc_plus4_o + br_offset_i, combinational.
redirect_cnt_o  output  CNT_W  count of taken branches and jumps.

Behaviour:
- Clocking and reset:
  - Single clock.
  - rst_i is synchronous and active-high. When rst_i=1 at a rising edge, the block enters state BOOT with:
    - pc_o = RESET_PC
    - imem_req_o = 0
    - instr_valid_o = 0
    - redirect_cnt_o = 0
  - Reset mid-fetch or mid-execute abandons the outstanding request; no PC update occurs.
- State machine (registered state; outputs decoded from state):
  - BOOT: imem_req_o=0, instr_valid_o=0. Always moves to FETCH next cycle.
  - FETCH: imem_req_o=1, instr_valid_o=0. Moves to EXEC on imem_ready_i=1; otherwise stays, with pc_o held.
  - EXEC: imem_req_o=0, instr_valid_o=1.
    - If stall_i=1: stays in EXEC; pc_o and counter held; branch_i and jump_i ignored.
    - If stall_i=0: pc_o <= next_pc and the state moves to FETCH.
- Next PC, evaluated only in EXEC with stall_i=0. Priority order:
  1. jump_i=1: {pc_plus4_o[31:28], jump_addr_i, 2'b00}.
  2. branch_i & zero_i: br_target_o.
  3. Otherwise: pc_plus4_o.
- Arithmetic:
  - Both additions are 32-bit modulo 2^32.
  - Wrap-around is silent (PC 32'hFFFF_FFFC + 4 = 32'h0000_0000).
  - No overflow flag.
- Alignment: pc_o[1:0] is always 2'b00; the low two bits of any computed target are forced to 0.
- redirect_cnt_o:
  - Increments by 1 on each EXEC-to-FETCH transition taken via a jump or a taken branch.
  - Saturates at all-ones; never wraps.
- imem_ready_i is ignored outside FETCH.
- branch_i, zero_i, jump_i and br_offset_i are ignored outside EXEC.
- Minimum instruction period with imem_ready_i tied high: 2 cycles (FETCH, EXEC) after the single BOOT cycle.

Test Plan:
- Reset and sequential fetch: rst_i pulse, then imem_ready_i=1 constant, no branches.
  - Required: BOOT for one cycle.
  - pc_o steps 0 -> 4 -> 8, each PC held for 2 cycles.
  - instr_valid_o high on the EXEC cycle only.
- Taken branch: pc_o=32'h0000_0010, branch_i=1, zero_i=1, br_offset_i=32'hFFFF_FFF0.
  - Required: next pc_o = 32'h0000_0004; redirect_cnt_o increments by 1.
  - Same stimulus with zero_i=0 gives 32'h0000_0014 and no increment.
- Jump priority: pc_o=32'h4000_0000, jump_i=1, branch_i=1, zero_i=1, jump_addr_i=26'h000_0100.
  - Required: next pc_o = 32'h4000_0400.
- Stall and handshake: hold imem_ready_i=0 for 3 cycles in FETCH, then assert stall_i for 2 EXEC cycles.
  - Required: imem_req_o stays high for 3+1 cycles.
  - instr_valid_o stays high across the stall.
  - pc_o unchanged until stall_i drops.
- Wrap and saturation: pc_o=32'hFFFF_FFFC with no branch.
  - Required: next pc_o = 32'h0000_0000.
  - With the counter preloaded via repeated jumps to 16'hFFFF, a further jump leaves it at 16'hFFFF.
- Reset mid-FETCH: assert rst_i while imem_req_o=1.
  - Required: next cycle pc_o=RESET_PC, imem_req_o=0, state BOOT.
